serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk input 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start input 1: operation request, sampled only in IDLE.
REQ-005 SHALL have port mode input 1: 0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 SHALL have port a input WIDTH: first operand, sampled with start.
REQ-007 SHALL have port b input WIDTH: second operand, sampled with start.
REQ-008 SHALL have port busy output 1: high while in SHIFT.
REQ-009 SHALL have port done output 1: one-cycle pulse, result valid.
REQ-010 SHALL have port sum output WIDTH: registered result.
REQ-011 SHALL have port cout output 1: final carry; for subtract, 1 = no borrow (a >= b unsigned).
REQ-012 SHALL have port ovf output 1, present only under SERIAL_ADDSUB_OVF_EN: signed overflow.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 IDLE, start=1 at edge k: SHALL load a_reg=a, b_reg=(mode ? ~b : b), carry=mode, bit counter=0; next state SHIFT.
REQ-015 IDLE, start=0: SHALL stay IDLE, holding sum, cout, ovf.
REQ-016 SHIFT: each edge SHALL form a_reg[0]^b_reg[0]^carry, shift it into sum MSB (sum shifts right), shift a_reg/b_reg right, update carry with the majority function, increment counter.
REQ-017 SHIFT SHALL exit to DONE on the edge where counter == WIDTH-1, i.e. exactly WIDTH shift edges (k+1..k+WIDTH).
REQ-018 DONE: done=1 for exactly one cycle (k+WIDTH to k+WIDTH+1); sum/cout final; next state IDLE unconditionally.
REQ-019 start in SHIFT or DONE SHALL be ignored; a start held high is accepted in the following IDLE cycle; back-to-back issue interval WIDTH+2 cycles.
REQ-020 Changes on a, b, mode after acceptance SHALL not affect the result in progress.
REQ-021 sum, cout, ovf SHALL hold their final values from DONE until the next accepted start; sum is undefined-by-contract (partial) while busy.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; cout is the carry out of bit WIDTH-1.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counters and operand registers 0.
REQ-024 rst asserted mid-operation SHALL abort it with no done pulse; first start after rst release is accepted normally.

Configuration
REQ-025 With SERIAL_ADDSUB_OVF_EN defined, SHALL register ovf = carry into bit WIDTH-1 XOR cout at the last shift, held as REQ-021.
REQ-026 Without SERIAL_ADDSUB_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package serial_addsub_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and the MODE_ADD/MODE_SUB constants.
REQ-028 Bit arithmetic SHALL be a sub-module fa_bit (inputs x, y, cin; outputs s, cout), instantiated once.
REQ-029 Counter width SHALL be $clog2(WIDTH).

Verification
REQ-030 WIDTH=4, add, a=0011, b=1011 -> sum=1110, cout=0, ovf=0; done exactly 4 edges after accept edge.
REQ-031 WIDTH=4, sub, a=0011, b=1011 -> sum=1000, cout=0, ovf=1.
REQ-032 WIDTH=4, sub, a=0011, b=0011 -> sum=0000, cout=1, ovf=0.
REQ-033 WIDTH=8, add, a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; busy high 8 cycles, done high 1 cycle.
REQ-034 WIDTH=8, start pulsed again 3 cycles into SHIFT with different operands -> ignored, first result unchanged, one done pulse.
REQ-035 WIDTH=8, rst asserted 5 cycles into SHIFT -> all outputs 0, IDLE, no done; next start a=8'h10, b=8'h20 add -> sum=8'h30, cout=0.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_bit.sv
// Single-bit full adder used as the serial datapath slice.
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single full adder.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_co;
    logic last_c;

    fa_bit u_fa (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign last_c = (cnt_q == CW'(WIDTH - 1));

    // Next-state and datapath control; subtraction is a + ~b + 1 via carry-in.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = (mode == MODE_SUB) ? ~b : b;
                    carry_d = mode;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (last_c) begin
                    cout_d  = fa_co;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d   = carry_q ^ fa_co;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: WIDTH=4 and WIDTH=8 instances against an arithmetic timeline model.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start_v [2];
    logic       mode_v  [2];
    logic [7:0] a_v     [2];
    logic [7:0] b_v     [2];

    logic       busy4, done4, cout4;
    logic [3:0] sum4;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic       ovf4, ovf8;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start_v[0]),
        .mode  (mode_v[0]),
        .a     (a_v[0][3:0]),
        .b     (b_v[0][3:0]),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start_v[1]),
        .mode  (mode_v[1]),
        .a     (a_v[1]),
        .b     (b_v[1]),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    function automatic int unsigned w_of(input int i);
        return (i == 0) ? 4 : 8;
    endfunction
    function automatic logic o_busy(input int i);
        return (i == 0) ? busy4 : busy8;
    endfunction
    function automatic logic o_done(input int i);
        return (i == 0) ? done4 : done8;
    endfunction
    function automatic logic [7:0] o_sum(input int i);
        return (i == 0) ? {4'b0, sum4} : sum8;
    endfunction
    function automatic logic o_cout(input int i);
        return (i == 0) ? cout4 : cout8;
    endfunction
`ifdef SERIAL_ADDSUB_OVF_EN
    function automatic logic o_ovf(input int i);
        return (i == 0) ? ovf4 : ovf8;
    endfunction
`endif

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (WIDTH=%0d) got %0h expected %0h at %0t", name, w_of(i), act, exp, $time);
        end
    endtask

    // Reference result from plain unsigned/signed integer arithmetic.
    task automatic ref_op(input int unsigned w, input logic m, input logic [7:0] x, input logic [7:0] y,
                          output logic [7:0] s, output logic c, output logic v);
        longint span, ux, uy, sx, sy, full, r;
        span = longint'(1) << w;
        ux   = longint'(x) & (span - 1);
        uy   = longint'(y) & (span - 1);
        sx   = (ux >= span / 2) ? ux - span : ux;
        sy   = (uy >= span / 2) ? uy - span : uy;
        if (m) begin
            full = ux - uy;
            c    = (ux >= uy);
            r    = sx - sy;
        end else begin
            full = ux + uy;
            c    = (full >= span);
            r    = sx + sy;
        end
        s = 8'(full & (span - 1));
        v = (r < -(span / 2)) || (r >= span / 2);
    endtask

    // Timeline model: accept in idle, busy for WIDTH cycles, one done cycle, results held.
    int         m_left [2] = '{0, 0};
    bit         m_done [2] = '{0, 0};
    logic [7:0] m_sum  [2] = '{8'h0, 8'h0};
    logic       m_cout [2] = '{1'b0, 1'b0};
    logic       m_ovf  [2] = '{1'b0, 1'b0};
    logic [7:0] p_sum  [2];
    logic       p_cout [2];
    logic       p_ovf  [2];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_left[i] = 0;
                m_done[i] = 0;
                m_sum[i]  = 8'h0;
                m_cout[i] = 1'b0;
                m_ovf[i]  = 1'b0;
            end else if (m_left[i] > 0) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_done[i] = 1;
                    m_sum[i]  = p_sum[i];
                    m_cout[i] = p_cout[i];
                    m_ovf[i]  = p_ovf[i];
                end
            end else if (m_done[i]) begin
                m_done[i] = 0;
            end else if (start_v[i] === 1'b1) begin
                ref_op(w_of(i), mode_v[i], a_v[i], b_v[i], p_sum[i], p_cout[i], p_ovf[i]);
                m_left[i] = int'(w_of(i));
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("busy", i, 32'(o_busy(i)), 32'(m_left[i] > 0));
            chk("done", i, 32'(o_done(i)), 32'(m_done[i]));
            if (m_left[i] == 0) begin
                chk("sum", i, 32'(o_sum(i)), 32'(m_sum[i]));
                chk("cout", i, 32'(o_cout(i)), 32'(m_cout[i]));
`ifdef SERIAL_ADDSUB_OVF_EN
                chk("ovf", i, 32'(o_ovf(i)), 32'(m_ovf[i]));
`endif
            end
        end
    end

    // Issue one operation from idle; returns edges from accept to done and busy cycles seen.
    task automatic issue(input int i, input logic m, input logic [7:0] x, input logic [7:0] y,
                         output int lat, output int nbusy);
        @(negedge clk);
        start_v[i] = 1'b1;
        mode_v[i]  = m;
        a_v[i]     = x;
        b_v[i]     = y;
        @(negedge clk);
        start_v[i] = 1'b0;
        a_v[i]     = 8'($urandom);
        b_v[i]     = 8'($urandom);
        mode_v[i]  = 1'($urandom);
        lat   = 0;
        nbusy = 0;
        while (o_done(i) !== 1'b1 && lat < 40) begin
            if (o_busy(i) === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic directed(input int i, input string name, input logic m, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] es, input logic ec, input logic ev);
        int lat, nbusy;
        issue(i, m, x, y, lat, nbusy);
        chk({name, "_latency"}, i, 32'(lat), 32'(w_of(i)));
        chk({name, "_busy_cycles"}, i, 32'(nbusy), 32'(w_of(i)));
        chk({name, "_sum"}, i, 32'(o_sum(i)), 32'(es));
        chk({name, "_cout"}, i, 32'(o_cout(i)), 32'(ec));
`ifdef SERIAL_ADDSUB_OVF_EN
        chk({name, "_ovf"}, i, 32'(o_ovf(i)), 32'(ev));
`else
        if (ev === 1'bx) $display("note: unexpected x");
`endif
        @(negedge clk);
        chk({name, "_done_width"}, i, 32'(o_done(i)), 32'd0);
    endtask

    initial begin
        int dones, lat, nbusy;
        logic [7:0] s1;
        logic       c1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = 1'b0;
            a_v[i]     = 8'h0;
            b_v[i]     = 8'h0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy", i, 32'(o_busy(i)), 32'd0);
            chk("reset_done", i, 32'(o_done(i)), 32'd0);
            chk("reset_sum", i, 32'(o_sum(i)), 32'd0);
            chk("reset_cout", i, 32'(o_cout(i)), 32'd0);
        end
        rst = 1'b0;

        directed(0, "add_3_11", 1'b0, 8'h3, 8'hB, 8'hE, 1'b0, 1'b0);
        directed(0, "sub_3_11", 1'b1, 8'h3, 8'hB, 8'h8, 1'b0, 1'b1);
        directed(0, "sub_3_3",  1'b1, 8'h3, 8'h3, 8'h0, 1'b1, 1'b0);
        directed(0, "sub_11_3", 1'b1, 8'hB, 8'h3, 8'h8, 1'b1, 1'b0);
        directed(1, "add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        directed(1, "sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

        // Second start three cycles into SHIFT must be ignored.
        @(negedge clk);
        start_v[1] = 1'b1; mode_v[1] = 1'b0; a_v[1] = 8'h5A; b_v[1] = 8'h33;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        start_v[1] = 1'b1; mode_v[1] = 1'b1; a_v[1] = 8'hFF; b_v[1] = 8'hFF;
        @(negedge clk);
        start_v[1] = 1'b0;
        dones = 0; s1 = 8'h0; c1 = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (o_done(1) === 1'b1) begin
                if (dones == 0) begin s1 = o_sum(1); c1 = o_cout(1); end
                dones++;
            end
        end
        chk("ignore_start_dones", 1, 32'(dones), 32'd1);
        chk("ignore_start_sum", 1, 32'(s1), 32'h8D);
        chk("ignore_start_cout", 1, 32'(c1), 32'd0);

        // Reset five cycles into SHIFT aborts with no done pulse.
        @(negedge clk);
        start_v[1] = 1'b1; mode_v[1] = 1'b0; a_v[1] = 8'h77; b_v[1] = 8'h11;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 1, 32'(o_busy(1)), 32'd0);
        chk("abort_done", 1, 32'(o_done(1)), 32'd0);
        chk("abort_sum", 1, 32'(o_sum(1)), 32'd0);
        chk("abort_cout", 1, 32'(o_cout(1)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (o_done(1) === 1'b1) dones++;
        end
        chk("abort_no_done", 1, 32'(dones), 32'd0);
        issue(1, 1'b0, 8'h10, 8'h20, lat, nbusy);
        chk("after_abort_latency", 1, 32'(lat), 32'd8);
        chk("after_abort_sum", 1, 32'(o_sum(1)), 32'h30);
        chk("after_abort_cout", 1, 32'(o_cout(1)), 32'd0);

        // Random traffic on both instances, including starts while busy and operand churn.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                start_v[i] = ($urandom_range(0, 2) == 0);
                mode_v[i]  = 1'($urandom);
                a_v[i]     = 8'($urandom);
                b_v[i]     = 8'($urandom);
            end
        end
        @(negedge clk);
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
